// File: rtl/branch_resolve_tracker.sv
// Branch tag tracker: keeps the live set and age ordering of in-flight
// branch tags, resolves up to two branches per cycle, and produces
// registered clear enables, a one-cycle recovery pulse with squash mask,
// and a one-cycle stall after each recovery.

// Per-tag state: live bit plus the row of older tags this branch depends on.
module brt_tag_entry #(
  parameter int NTAG = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            set,      // allocate this tag
  input  logic [NTAG-1:0] set_dep,  // older tags at allocation
  input  logic            kill,     // free this tag (resolve or squash)
  input  logic [NTAG-1:0] clr_col,  // tags freed this cycle anywhere
  output logic            live,
  output logic [NTAG-1:0] dep
);

  // Freeing wins over allocation; a free column is dropped from every row.
  always_ff @(posedge clock) begin
    if (!reset) begin
      live <= 1'b0;
      dep  <= '0;
    end else if (kill) begin
      live <= 1'b0;
      dep  <= '0;
    end else if (set) begin
      live <= 1'b1;
      dep  <= set_dep & ~clr_col;
    end else begin
      dep  <= dep & ~clr_col;
    end
  end

endmodule

module branch_resolve_tracker #(
  parameter int NTAG  = 4,
  parameter int TAG_W = 2,
  parameter int PC_W  = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic [NTAG-1:0]  alloc_bmask,
  input  logic             res_valid_1,
  input  logic [TAG_W-1:0] res_tag_1,
  input  logic             res_mispr_1,
  input  logic [PC_W-1:0]  res_target_1,
  input  logic             res_valid_2,
  input  logic [TAG_W-1:0] res_tag_2,
  input  logic             res_mispr_2,
  input  logic [PC_W-1:0]  res_target_2,
  output logic             cl_enable_1,
  output logic             cl_enable_2,
  output logic             cl_enable_3,
  output logic             cl_enable_4,
  output logic [TAG_W-1:0] cl_position_1,
  output logic [TAG_W-1:0] cl_position_2,
  output logic [TAG_W-1:0] cl_position_3,
  output logic [TAG_W-1:0] cl_position_4,
  output logic             recover,
  output logic [PC_W-1:0]  recover_pc,
  output logic [NTAG-1:0]  squash_mask,
  output logic             stall
);

  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             mispr;
    logic [PC_W-1:0]  tgt;
  } res_t;

  logic [0:0]                  state;
  logic [NTAG-1:0]             live_vec;
  logic [NTAG-1:0][NTAG-1:0]   dep;
  res_t                        r1, r2;
  logic                        normal, v1, v2, mp1, mp2, use2, mis;
  logic [TAG_W-1:0]            m_tag;
  logic [PC_W-1:0]             m_pc;
  logic [NTAG-1:0]             kill, corr, free_set;
  logic                        alloc_ok;

  logic [NTAG-1:0]             cl_en_q;
  logic [NTAG-1:0][TAG_W-1:0]  pos_q;
  logic                        rec_q, stall_q;
  logic [PC_W-1:0]             pc_q;
  logic [NTAG-1:0]             mask_q;

  assign r1 = '{vld: res_valid_1, tag: res_tag_1, mispr: res_mispr_1, tgt: res_target_1};
  assign r2 = '{vld: res_valid_2, tag: res_tag_2, mispr: res_mispr_2, tgt: res_target_2};

  // Resolutions count only in NORMAL and only for live tags; port 1 owns a shared tag.
  assign normal = (state == ST_NORMAL);
  assign v1     = normal & r1.vld & live_vec[r1.tag];
  assign v2     = normal & r2.vld & live_vec[r2.tag] & ~(r1.vld & (r1.tag == r2.tag));
  assign mp1    = v1 & r1.mispr;
  assign mp2    = v2 & r2.mispr;
  // Port 2 takes the recovery only when its branch is older than port 1's.
  assign use2   = mp2 & (~mp1 | dep[r1.tag][r2.tag]);
  assign mis    = mp1 | mp2;
  assign m_tag  = use2 ? r2.tag : r1.tag;
  assign m_pc   = use2 ? r2.tgt : r1.tgt;

  // Kill set: the mispredicted tag, every live younger tag, and a same-cycle alloc.
  always_comb begin
    kill = '0;
    if (mis) begin
      kill[m_tag] = 1'b1;
      for (int x = 0; x < NTAG; x++)
        if (live_vec[x] && dep[x][m_tag]) kill[x] = 1'b1;
      if (alloc_en) kill[alloc_tag] = 1'b1;
    end
  end

  // Correct resolves that survive the squash.
  always_comb begin
    corr = '0;
    if (v1 && !r1.mispr) corr[r1.tag] = 1'b1;
    if (v2 && !r2.mispr) corr[r2.tag] = 1'b1;
    corr = corr & ~kill;
  end

  assign free_set = kill | corr;
  assign alloc_ok = normal & alloc_en & ~mis;

  for (genvar t = 0; t < NTAG; t++) begin : g_tag
    brt_tag_entry #(.NTAG(NTAG)) u_ent (
      .clock   (clock),
      .reset   (reset),
      .set     (alloc_ok && (alloc_tag == TAG_W'(t))),
      .set_dep (alloc_bmask),
      .kill    (free_set[t]),
      .clr_col (free_set),
      .live    (live_vec[t]),
      .dep     (dep[t])
    );
  end

  // Recovery FSM plus the registered output stage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_NORMAL;
      cl_en_q <= '0;
      pos_q   <= '0;
      rec_q   <= 1'b0;
      pc_q    <= '0;
      mask_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state   <= mis ? ST_RECOVER : ST_NORMAL;
      cl_en_q <= free_set;
      for (int k = 0; k < NTAG; k++) pos_q[k] <= TAG_W'(k);
      rec_q   <= mis;
      pc_q    <= mis ? m_pc : '0;
      mask_q  <= mis ? kill : '0;
      stall_q <= (state == ST_RECOVER);
    end
  end

  assign cl_enable_1   = cl_en_q[0];
  assign cl_enable_2   = cl_en_q[1];
  assign cl_enable_3   = cl_en_q[2];
  assign cl_enable_4   = cl_en_q[3];
  assign cl_position_1 = pos_q[0];
  assign cl_position_2 = pos_q[1];
  assign cl_position_3 = pos_q[2];
  assign cl_position_4 = pos_q[3];
  assign recover       = rec_q;
  assign recover_pc    = pc_q;
  assign squash_mask   = mask_q;
  assign stall         = stall_q;

  // Allocating a tag that is still in flight is a front-end protocol error.
  a_alloc_free: assert property (@(posedge clock) disable iff (!reset)
    (normal && alloc_en) |-> !live_vec[alloc_tag]);

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Scoreboard bench for branch_resolve_tracker. The reference model keeps
// live branches as a program-ordered list (oldest first); the squash set of
// a mispredict is simply that branch and everything after it in the list.
module tb_branch_resolve_tracker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alloc_en = 1'b0;
  logic [1:0]  alloc_tag = '0;
  logic [3:0]  alloc_bmask = '0;
  logic        res_valid_1 = 1'b0, res_valid_2 = 1'b0;
  logic [1:0]  res_tag_1 = '0, res_tag_2 = '0;
  logic        res_mispr_1 = 1'b0, res_mispr_2 = 1'b0;
  logic [63:0] res_target_1 = '0, res_target_2 = '0;
  logic        cl_enable_1, cl_enable_2, cl_enable_3, cl_enable_4;
  logic [1:0]  cl_position_1, cl_position_2, cl_position_3, cl_position_4;
  logic        recover, stall;
  logic [63:0] recover_pc;
  logic [3:0]  squash_mask;

  branch_resolve_tracker #(.NTAG(4), .TAG_W(2), .PC_W(64)) dut (
    .clock(clock), .reset(reset),
    .alloc_en(alloc_en), .alloc_tag(alloc_tag), .alloc_bmask(alloc_bmask),
    .res_valid_1(res_valid_1), .res_tag_1(res_tag_1), .res_mispr_1(res_mispr_1),
    .res_target_1(res_target_1),
    .res_valid_2(res_valid_2), .res_tag_2(res_tag_2), .res_mispr_2(res_mispr_2),
    .res_target_2(res_target_2),
    .cl_enable_1(cl_enable_1), .cl_enable_2(cl_enable_2),
    .cl_enable_3(cl_enable_3), .cl_enable_4(cl_enable_4),
    .cl_position_1(cl_position_1), .cl_position_2(cl_position_2),
    .cl_position_3(cl_position_3), .cl_position_4(cl_position_4),
    .recover(recover), .recover_pc(recover_pc), .squash_mask(squash_mask),
    .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [3:0]  cl;
    logic        rec;
    logic [63:0] pc;
    logic [3:0]  mask;
    logic        st;
  } exp_t;

  exp_t sbq[$];
  int   order[$];     // live tags, oldest first
  bit   m_rec = 0;    // model: next window is the recovery window
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  bit   mon_en = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic int pos_of(input int t);
    foreach (order[i]) if (order[i] == t) return i;
    return -1;
  endfunction

  function automatic logic [3:0] live_mask();
    logic [3:0] m = '0;
    foreach (order[i]) m[order[i]] = 1'b1;
    return m;
  endfunction

  function automatic void drop(input logic [3:0] s);
    int keep[$];
    foreach (order[i]) if (!s[order[i]]) keep.push_back(order[i]);
    order = keep;
  endfunction

  function automatic int pick_free();
    logic [3:0] lm = live_mask();
    int c[$];
    for (int t = 0; t < 4; t++) if (!lm[t]) c.push_back(t);
    if (c.size() == 0) return -1;
    return c[$urandom_range(c.size() - 1)];
  endfunction

  // Drive one cycle of inputs, advance the model, then step past the edge.
  task automatic step(input bit rst, input bit ae, input int at,
                      input bit rv1, input int t1, input bit mp1, input logic [63:0] pc1,
                      input bit rv2, input int t2, input bit mp2, input logic [63:0] pc2);
    int p1, p2, win;
    logic [3:0] kill, freed;
    logic [63:0] wpc;
    reset = rst;  alloc_en = ae;  alloc_tag = at[1:0];  alloc_bmask = live_mask();
    res_valid_1 = rv1; res_tag_1 = t1[1:0]; res_mispr_1 = mp1; res_target_1 = pc1;
    res_valid_2 = rv2; res_tag_2 = t2[1:0]; res_mispr_2 = mp2; res_target_2 = pc2;
    if (!rst) begin
      order.delete();
      m_rec = 0;
    end else if (m_rec) begin
      sbq.push_back('{cyc + 1, 4'b0, 1'b0, 64'd0, 4'b0, 1'b1});
      m_rec = 0;
    end else begin
      p1 = rv1 ? pos_of(t1) : -1;
      p2 = (rv2 && !(rv1 && t1 == t2)) ? pos_of(t2) : -1;
      win = -1;  wpc = '0;  kill = '0;
      if (p1 >= 0 && mp1) begin win = p1; wpc = pc1; end
      if (p2 >= 0 && mp2 && (win < 0 || p2 < win)) begin win = p2; wpc = pc2; end
      if (win >= 0) begin
        for (int i = win; i < order.size(); i++) kill[order[i]] = 1'b1;
        if (ae) kill[at] = 1'b1;
      end
      freed = kill;
      if (p1 >= 0 && !mp1 && !kill[t1]) freed[t1] = 1'b1;
      if (p2 >= 0 && !mp2 && !kill[t2]) freed[t2] = 1'b1;
      drop(freed);
      if (win < 0 && ae) order.push_back(at);
      if (win >= 0) begin
        sbq.push_back('{cyc + 1, freed, 1'b1, wpc, kill, 1'b0});
        m_rec = 1;
      end else if (freed != 0) begin
        sbq.push_back('{cyc + 1, freed, 1'b0, 64'd0, 4'b0, 1'b0});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input int t);
    step(1, 1, t, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: whenever the DUT shows activity, pop and compare.
  always @(negedge clock) begin
    if (mon_en) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        chk("missing_output_cycle", 128'(cyc), 128'(sbq[0].cyc));
        void'(sbq.pop_front());
      end
      if (cl_enable_1 || cl_enable_2 || cl_enable_3 || cl_enable_4 || recover || stall) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output",
              128'({cl_enable_4, cl_enable_3, cl_enable_2, cl_enable_1, recover, squash_mask, stall}),
              128'(0));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("output_cycle", 128'(cyc), 128'(e.cyc));
          chk("output_fields",
              128'({cl_enable_4, cl_enable_3, cl_enable_2, cl_enable_1, recover, recover_pc,
                    squash_mask, stall}),
              128'({e.cl, e.rec, e.pc, e.mask, e.st}));
        end
      end
    end
  end

  initial begin
    fork
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
      end
    join_none

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs",
        128'({cl_enable_4, cl_enable_3, cl_enable_2, cl_enable_1, cl_position_4, cl_position_3,
              cl_position_2, cl_position_1, recover, recover_pc, squash_mask, stall}),
        128'(0));
    mon_en = 1;
    idle();
    chk("cl_position", 128'({cl_position_4, cl_position_3, cl_position_2, cl_position_1}),
        128'(8'b11_10_01_00));

    // 1: alloc t0, correct resolve on FU1
    alloc(0);
    step(1, 0, 0, 1, 0, 0, 64'h0, 0, 0, 0, 0);
    idle();

    // 2: t0 < t1 < t2, mispredict t1 -> squash 0110, then stall
    alloc(0); alloc(1); alloc(2);
    step(1, 0, 0, 1, 1, 1, 64'h400, 0, 0, 0, 0);
    idle(); idle();

    // 3: t0 < t1, both mispredict; FU2's older branch wins
    alloc(1);
    step(1, 0, 0, 1, 1, 1, 64'h1111, 1, 0, 1, 64'h2222);
    idle(); idle();

    // 4: t1 correct while older t0 mispredicts
    alloc(0); alloc(1);
    step(1, 0, 0, 1, 1, 0, 64'h0, 1, 0, 1, 64'h3333);
    idle(); idle();

    // 5: alloc t3 in the mispredict cycle of t0; t3 must not become live
    alloc(0);
    step(1, 1, 3, 1, 0, 1, 64'h5555, 0, 0, 0, 0);
    idle();
    step(1, 0, 0, 1, 3, 0, 64'h0, 0, 0, 0, 0);
    idle();

    // 6: reset lands on the edge that would launch recovery
    alloc(0);
    step(0, 0, 0, 1, 0, 1, 64'h6666, 0, 0, 0, 0);
    chk("reset_mid_run",
        128'({cl_enable_4, cl_enable_3, cl_enable_2, cl_enable_1, cl_position_4, cl_position_3,
              cl_position_2, cl_position_1, recover, recover_pc, squash_mask, stall}),
        128'(0));
    idle(); idle();
    alloc(0);
    step(1, 0, 0, 1, 0, 0, 64'h0, 0, 0, 0, 0);
    idle();

    // Random traffic, biased toward live tags
    for (int n = 0; n < 3000; n++) begin
      int at, t1, t2;
      bit ae, rst;
      at  = pick_free();
      ae  = (at >= 0) && ($urandom_range(2) == 0);
      if (at < 0) at = 0;
      t1  = (order.size() > 0 && $urandom_range(3) != 0) ? order[$urandom_range(order.size() - 1)]
                                                          : int'($urandom_range(3));
      t2  = (order.size() > 0 && $urandom_range(3) != 0) ? order[$urandom_range(order.size() - 1)]
                                                          : int'($urandom_range(3));
      rst = ($urandom_range(199) != 0);
      step(rst, ae, at,
           $urandom_range(1) == 1, t1, $urandom_range(3) == 0, {$urandom, $urandom},
           $urandom_range(1) == 1, t2, $urandom_range(3) == 0, {$urandom, $urandom});
    end

    repeat (4) idle();
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
